// File: rtl/vga_vram_arbiter_if.sv
// Avalon-MM slave bundle between the fabric and the VRAM arbiter.
//   cs/read/write/addr/byte_en/writedata : master -> arbiter request
//   readdata/waitrequest                 : arbiter -> master response
// addr[11] = 0 selects VRAM words, addr[11] = 1 selects control registers.
interface vga_vram_arbiter_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [11:0] addr;
  logic [3:0]  byte_en;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport slave  (input  cs, read, write, addr, byte_en, writedata,
                  output readdata, waitrequest);
  modport master (output cs, read, write, addr, byte_en, writedata,
                  input  readdata, waitrequest);
endinterface

// File: rtl/vga_vram_arbiter.sv
// Shares VRAM port A between the CPU Avalon slave and a FILL / SCROLL-UP engine.
// Ports:
//   clk, rst_n      : system clock, async active-low reset
//   avl             : Avalon-MM slave (VRAM window + CMD/FILL_DATA/STATUS regs)
//   ram_*_o         : port A address, byte enables, write data, strobes
//   ram_q_i         : port A read data, valid the cycle after ram_rden_o
//   irq_o           : level interrupt, DONE & IRQ_EN
module vga_vram_arbiter #(
  parameter int VRAM_WORDS = 1200,
  parameter int ROW_WORDS  = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  vga_vram_arbiter_if.slave        avl,
  output logic [10:0]              ram_addr_o,
  output logic [3:0]               ram_byteen_o,
  output logic [31:0]              ram_wdata_o,
  output logic                     ram_wren_o,
  output logic                     ram_rden_o,
  input  logic [31:0]              ram_q_i,
  output logic                     irq_o
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SCR_RD, S_SCR_WR, S_SCR_FILL, S_FIN} state_e;

  localparam logic [10:0] LAST_W  = 11'(VRAM_WORDS - 1);
  localparam logic [10:0] LAST_MV = 11'(VRAM_WORDS - ROW_WORDS - 1);
  localparam logic [10:0] ROW_W   = 11'(ROW_WORDS);
  localparam logic [10:0] DEPTH_W = 11'(VRAM_WORDS);

  state_e      state_q;
  logic [10:0] cnt_q;
  logic [31:0] fill_q, hold_q, rdata_q;
  logic        done_q, err_q, irq_en_q;
  logic        rr_q;                 // 1: CPU won the last contested cycle
  logic        cap_q;                // engine read issued last cycle, RAM_Q is ours
  logic        vpend_q, voor_q;      // CPU VRAM read data cycle / out-of-range
  logic        rpend_q;              // control register read data cycle

  logic        busy, pend, is_vram, in_range, wr_op;
  logic        cpu_req, eng_req, cpu_gnt, eng_gnt;
  logic        reg_rd, reg_wr, op_valid, start;
  logic [31:0] reg_rval, rd_mux;

  assign busy     = (state_q != S_IDLE);
  assign pend     = vpend_q | rpend_q;
  assign is_vram  = ~avl.addr[11];
  assign in_range = (avl.addr[10:0] < DEPTH_W);
  assign wr_op    = avl.write & ~avl.read;

  // The data cycle of a read is not a new request: the master still holds it.
  assign cpu_req = rst_n & avl.cs & is_vram & ((avl.read & ~pend) | wr_op);
  assign eng_req = (state_q == S_FILL) || (state_q == S_SCR_RD) ||
                   (state_q == S_SCR_WR) || (state_q == S_SCR_FILL);
  assign cpu_gnt = cpu_req & (~eng_req | ~rr_q);
  assign eng_gnt = eng_req & ~cpu_gnt;

  assign reg_rd   = rst_n & avl.cs & avl.addr[11] & avl.read & ~pend;
  assign reg_wr   = rst_n & avl.cs & avl.addr[11] & wr_op;
  assign op_valid = (avl.writedata[1:0] == 2'b01) || (avl.writedata[1:0] == 2'b10);
  assign start    = reg_wr & (avl.addr[1:0] == 2'd0) & op_valid & ~busy;

  always_comb begin
    reg_rval = '0;
    case (avl.addr[1:0])
      2'd1:    reg_rval = fill_q;
      2'd2:    reg_rval = {29'd0, err_q, done_q, busy};
      default: reg_rval = '0;
    endcase
  end

  assign rd_mux          = voor_q ? '0 : ram_q_i;
  assign avl.readdata    = vpend_q ? rd_mux : rdata_q;
  assign avl.waitrequest = rst_n & avl.cs &
                           ((avl.read & ~pend) | (wr_op & is_vram & ~cpu_gnt));
  assign irq_o           = done_q & irq_en_q;

  // Port A mux: CPU path is combinational so a granted write completes in-cycle.
  always_comb begin
    ram_addr_o   = '0;
    ram_byteen_o = '0;
    ram_wdata_o  = '0;
    ram_wren_o   = 1'b0;
    ram_rden_o   = 1'b0;
    if (cpu_gnt) begin
      ram_addr_o   = avl.addr[10:0];
      ram_byteen_o = avl.byte_en;
      ram_wdata_o  = avl.writedata;
      ram_wren_o   = wr_op & in_range;
      ram_rden_o   = avl.read & in_range;
    end else if (eng_gnt) begin
      ram_byteen_o = 4'hF;
      ram_addr_o   = cnt_q;
      case (state_q)
        S_FILL, S_SCR_FILL: begin
          ram_wdata_o = fill_q;
          ram_wren_o  = 1'b1;
        end
        S_SCR_RD: begin
          ram_addr_o  = cnt_q + ROW_W;
          ram_rden_o  = 1'b1;
        end
        S_SCR_WR: begin
          // First write attempt takes RAM_Q straight through; retries use hold.
          ram_wdata_o = cap_q ? ram_q_i : hold_q;
          ram_wren_o  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fill_q   <= '0;
      hold_q   <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      rr_q     <= 1'b0;
      cap_q    <= 1'b0;
      vpend_q  <= 1'b0;
      voor_q   <= 1'b0;
      rpend_q  <= 1'b0;
    end else begin
      vpend_q <= cpu_gnt & avl.read;
      voor_q  <= ~in_range;
      rpend_q <= reg_rd;
      if (reg_rd)  rdata_q <= reg_rval;
      if (vpend_q) rdata_q <= rd_mux;
      if (cpu_req & eng_req) rr_q <= cpu_gnt;

      cap_q <= eng_gnt & (state_q == S_SCR_RD);
      if (cap_q) hold_q <= ram_q_i;

      if (reg_wr) begin
        case (avl.addr[1:0])
          2'd0: begin
            irq_en_q <= avl.writedata[2];
            if (op_valid && busy) err_q <= 1'b1;
          end
          2'd1: fill_q <= avl.writedata;
          2'd2: begin
            if (avl.writedata[1]) done_q <= 1'b0;
            if (avl.writedata[2]) err_q  <= 1'b0;
          end
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: if (start) begin
          state_q <= (avl.writedata[1:0] == 2'b01) ? S_FILL : S_SCR_RD;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
        S_FILL, S_SCR_FILL: if (eng_gnt) begin
          if (cnt_q == LAST_W) state_q <= S_FIN;
          else                 cnt_q   <= cnt_q + 11'd1;
        end
        S_SCR_RD: if (eng_gnt) state_q <= S_SCR_WR;
        S_SCR_WR: if (eng_gnt) begin
          cnt_q   <= cnt_q + 11'd1;
          state_q <= (cnt_q == LAST_MV) ? S_SCR_FILL : S_SCR_RD;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
module tb_vga_vram_arbiter;
  localparam int WORDS = 1200;
  localparam int ROW   = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ram_addr;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata, ram_q;
  logic        ram_wren, ram_rden, irq;

  vga_vram_arbiter_if avl();

  vga_vram_arbiter #(.VRAM_WORDS(WORDS), .ROW_WORDS(ROW)) dut (
    .clk(clk), .rst_n(rst_n), .avl(avl),
    .ram_addr_o(ram_addr), .ram_byteen_o(ram_byteen), .ram_wdata_o(ram_wdata),
    .ram_wren_o(ram_wren), .ram_rden_o(ram_rden), .ram_q_i(ram_q), .irq_o(irq));

  always #10 clk = ~clk;

  // Dual-port RAM stand-in (port A side) with strobe bookkeeping.
  logic [31:0] mem [0:2047];
  logic [7:0]  seen_ep [0:2047];
  logic [7:0]  epoch = 8'd0;
  int          wr_cnt = 0, bad_cnt = 0;
  logic [3:0]  last_be = 4'd0;

  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      seen_ep[ram_addr] <= epoch;
      last_be <= ram_byteen;
      wr_cnt  <= wr_cnt + 1;
    end
    if (ram_rden) ram_q <= mem[ram_addr];
    if ((ram_wren || ram_rden) && ram_addr >= 11'(WORDS)) bad_cnt <= bad_cnt + 1;
  end

  // Reference model state.
  logic [31:0] ref_mem [0:WORDS-1];
  logic [31:0] ref_fill;
  logic        ref_done, ref_err;

  int n_pass = 0, n_total = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every completed Avalon read is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && avl.cs && avl.read && !avl.waitrequest) begin
      if (exp_q.size() == 0) check("read_unexpected", 32'd1, 32'd0);
      else check("read_data", avl.readdata, exp_q.pop_front());
    end
  end

  task automatic avl_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int waits);
    avl.cs = 1'b1; avl.write = 1'b1; avl.read = 1'b0;
    avl.addr = a; avl.writedata = d; avl.byte_en = be;
    waits = 0;
    @(negedge clk);
    while (avl.waitrequest && waits < 50) begin waits++; @(negedge clk); end
    if (waits >= 50) check("write_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    avl.cs = 1'b0; avl.write = 1'b0;
  endtask

  task automatic avl_read(input logic [11:0] a, input logic [31:0] exp, output int waits);
    exp_q.push_back(exp);
    avl.cs = 1'b1; avl.read = 1'b1; avl.write = 1'b0; avl.addr = a;
    waits = 0;
    @(negedge clk);
    while (avl.waitrequest && waits < 50) begin waits++; @(negedge clk); end
    if (waits >= 50) check("read_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    avl.cs = 1'b0; avl.read = 1'b0;
  endtask

  function automatic logic [31:0] ref_rd(input logic [11:0] a);
    if (a[11]) begin
      case (a[1:0])
        2'd1:    return ref_fill;
        2'd2:    return {29'd0, ref_err, ref_done, 1'b0};
        default: return 32'd0;
      endcase
    end
    return (a < 12'(WORDS)) ? ref_mem[a] : 32'd0;
  endfunction

  task automatic ref_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    if (!a[11] && a < 12'(WORDS))
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic ref_scroll();
    for (int i = 0; i < WORDS; i++)
      ref_mem[i] = (i < WORDS - ROW) ? ref_mem[i + ROW] : ref_fill;
  endtask

  function automatic int mem_mism();
    int m = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) m++;
    return m;
  endfunction

  task automatic wait_irq(input int lim, output int n);
    n = 1;
    while (!irq && n < lim) begin @(posedge clk); #1; n++; end
  endtask

  localparam logic [11:0] R_CMD = 12'h800, R_FD = 12'h801, R_ST = 12'h802, R_3 = 12'h803;

  initial begin
    int w, n, w0, ww;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    avl.cs = 0; avl.read = 0; avl.write = 0; avl.addr = '0;
    avl.byte_en = '0; avl.writedata = '0;
    ref_fill = 0; ref_done = 0; ref_err = 0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;

    repeat (3) @(negedge clk);
    check("reset_wren", {31'd0, ram_wren}, 32'd0);
    check("reset_rden", {31'd0, ram_rden}, 32'd0);
    check("reset_irq",  {31'd0, irq}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    avl_read(R_ST, 32'd0, w);

    // Byte-enabled CPU write then read-back
    avl_write(12'd5, 32'h12345678, 4'hF, w); ref_wr(12'd5, 32'h12345678, 4'hF);
    n = wr_cnt;
    avl_write(12'd5, 32'hDEADBEEF, 4'h3, w); ref_wr(12'd5, 32'hDEADBEEF, 4'h3);
    check("cpu_wr_wait", w, 0);
    check("cpu_wr_strobes", wr_cnt - n, 1);
    check("cpu_wr_byteen", {28'd0, last_be}, 32'h3);
    avl_read(12'd5, 32'h1234BEEF, w);
    check("cpu_rd_wait", w, 1);

    // Randomized CPU traffic, engine idle
    for (int k = 0; k < 80; k++) begin
      a = 12'($urandom_range(0, 2047)); d = $urandom; be = 4'($urandom);
      case ($urandom_range(0, 4))
        0, 1: begin avl_write(a, d, be, w); ref_wr(a, d, be); end
        2:    avl_read(a, ref_rd(a), w);
        3:    begin avl_write(R_FD, d, 4'hF, w); ref_fill = d; end
        default: begin
          a = ($urandom_range(0, 1) == 0) ? R_FD : R_3;
          avl_read(a, ref_rd(a), w);
        end
      endcase
    end

    // FILL, uncontested
    avl_write(R_FD, 32'h00200020, 4'hF, w); ref_fill = 32'h00200020;
    epoch = 8'd1; n = wr_cnt; w0 = bad_cnt;
    avl_write(R_CMD, 32'h5, 4'hF, w);
    wait_irq(3000, ww);
    check("fill_cycles", ww, 1202);
    check("fill_strobes", wr_cnt - n, 1200);
    n = 0;
    for (int i = 0; i < WORDS; i++) if (seen_ep[i] == 8'd1) n++;
    check("fill_coverage", n, 1200);
    for (int i = 0; i < WORDS; i++) ref_mem[i] = ref_fill;
    ref_done = 1;
    check("fill_mem", mem_mism(), 0);
    avl_read(R_ST, ref_rd(R_ST), w);
    avl_write(R_ST, 32'h2, 4'hF, w); ref_done = 0;
    check("irq_clear", {31'd0, irq}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      a = 12'($urandom_range(0, WORDS - 1)); avl_read(a, ref_rd(a), w);
    end

    // SCROLL, uncontested, word i = i
    for (int i = 0; i < WORDS; i++) begin
      avl_write(12'(i), 32'(i), 4'hF, w); ref_mem[i] = 32'(i);
    end
    avl_write(R_FD, 32'd0, 4'hF, w); ref_fill = 0;
    avl_write(R_CMD, 32'h6, 4'hF, w);
    wait_irq(5000, ww);
    check("scroll_cycles", ww, 2362);
    ref_scroll(); ref_done = 1;
    check("scroll_mem", mem_mism(), 0);
    check("scroll_addr_range", bad_cnt - w0, 0);
    avl_read(R_ST, ref_rd(R_ST), w);
    avl_write(R_ST, 32'h2, 4'hF, w); ref_done = 0;

    // SCROLL contested by back-to-back CPU reads, plus CMD while busy
    for (int i = 0; i < WORDS; i++) begin
      d = $urandom; avl_write(12'(i), d, 4'hF, w); ref_mem[i] = d;
    end
    avl_write(R_CMD, 32'h6, 4'hF, w);
    n = 0;
    for (int k = 0; k < 150; k++) begin
      a = 12'($urandom_range(WORDS, 2047));
      avl_read(a, 32'd0, w);
      if (k == 0) w0 = w;
      else if (w != 2) n++;
    end
    check("rr_first_to_cpu", w0, 1);
    check("rr_alternate", n, 0);
    avl_write(R_CMD, 32'h5, 4'hF, w); ref_err = 1;
    wait_irq(8000, ww);
    check("contested_done", {31'd0, irq}, 32'd1);
    ref_scroll(); ref_done = 1;
    check("contested_mem", mem_mism(), 0);
    avl_read(R_ST, ref_rd(R_ST), w);
    avl_write(R_ST, 32'h6, 4'hF, w); ref_done = 0; ref_err = 0;
    avl_read(R_ST, ref_rd(R_ST), w);

    // Reset in the middle of a FILL
    avl_write(R_FD, 32'hA5A5A5A5, 4'hF, w); ref_fill = 32'hA5A5A5A5;
    n = wr_cnt;
    avl_write(R_CMD, 32'h1, 4'hF, w);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midreset_started", (wr_cnt - n > 50) ? 32'd1 : 32'd0, 32'd1);
    check("midreset_wren", {31'd0, ram_wren}, 32'd0);
    n = wr_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ref_fill = 0; ref_done = 0; ref_err = 0;
    repeat (50) @(posedge clk);
    #1;
    check("midreset_no_writes", wr_cnt - n, 0);
    avl_read(R_ST, ref_rd(R_ST), w);
    avl_read(R_FD, ref_rd(R_FD), w);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Owns write/read port A of the text-mode VRAM and shares it between the Avalon-MM CPU slave and an internal hardware engine. The engine performs whole-screen FILL and one-row SCROLL-UP, so software never copies 1200 words. It sits between the Avalon fabric and the dual-port VRAM. Port B stays with the VGA raster fetch and is untouched.

## Interface
- VRAM_WORDS, 1200: VRAM depth in 32-bit words (80x30 chars, 2 chars/word).
- ROW_WORDS, 40: words per text row.
- CLK  in  1  50 MHz system clock.
- RESET  in  1  asynchronous, active-low reset.
- AVL_CS, AVL_READ, AVL_WRITE  in  1  Avalon-MM slave controls.
- AVL_ADDR  in  12  word address. Bit 11 = 0 selects VRAM; bit 11 = 1 selects the control registers.
- AVL_BYTE_EN  in  4  byte enables; applies to VRAM writes only.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data.
- AVL_WAITREQUEST  out  1  stall to master.
- RAM_ADDR  out  11  port A word address.
- RAM_BYTEEN  out  4  port A byte enables.
- RAM_WDATA  out  32  port A write data.
- RAM_WREN, RAM_RDEN  out  1  port A strobes.
- RAM_Q  in  32  port A read data, valid the cycle after RAM_RDEN.
- IRQ  out  1  done interrupt, level.

## Operation
- Control registers (AVL_ADDR[1:0] when bit 11 = 1):
  - 0: CMD, write-only. Bits [1:0] are the op: 01 FILL, 10 SCROLL, others no-op. Bit 2 is IRQ_EN and is latched on every CMD write.
  - 1: FILL_DATA, read/write, 32 bits.
  - 2: STATUS. Bit 0 is BUSY. Bit 1 is DONE, sticky, cleared by writing 1. Bit 2 is ERR, sticky, cleared by writing 1.
  - 3: reads 0.
- IRQ = DONE & IRQ_EN.
- CMD write with a valid op while BUSY: the op is ignored and ERR is set.
- CMD write with a valid op while idle: BUSY sets next cycle and DONE clears.
- Engine FSM:
  - IDLE: BUSY = 0.
  - FILL: write FILL_DATA to words 0..VRAM_WORDS-1 with byte enables 1111, one word per granted cycle. After the last write, go to FIN.
  - SCR_RD: issue a read of src = dst + ROW_WORDS. The next cycle, RAM_Q is captured into the hold register unconditionally, even if the CPU owns that cycle. Then go to SCR_WR.
  - SCR_WR: write the hold register to dst and increment dst. At dst = VRAM_WORDS-ROW_WORDS, go to SCR_FILL; otherwise go back to SCR_RD.
  - SCR_FILL: write FILL_DATA to the last ROW_WORDS words, then go to FIN.
  - FIN: one cycle. Set DONE, clear BUSY, return to IDLE.
- Counters are 11 bits. Addresses never exceed VRAM_WORDS-1.
- CPU VRAM access at or above VRAM_WORDS:
  - Writes are dropped; waitrequest behaves as a normal write.
  - Reads return 0.
- Arbitration, per cycle, when both the CPU (CS & (READ|WRITE) to VRAM) and the engine (in FILL, SCR_RD, SCR_WR or SCR_FILL) want the port:
  - The grant goes to whichever did not win the last contested cycle (round-robin).
  - The first contest after reset goes to the CPU.
  - An uncontested requester always wins.
- Control-register accesses never use the port and are never arbitrated.
- Reset: all outputs 0; FSM in IDLE; FILL_DATA, STATUS, IRQ_EN, counters and the round-robin pointer all 0. Reset mid-operation aborts the engine; VRAM contents are left partially updated.

## Timing
- CPU VRAM write:
  - Granted: RAM_WREN is driven combinationally in the same cycle and AVL_WAITREQUEST = 0.
  - Not granted: AVL_WAITREQUEST = 1 and no RAM strobe.
- CPU VRAM read:
  - Cycle t, granted: RAM_RDEN is asserted and AVL_WAITREQUEST = 1.
  - Cycle t+1: AVL_WAITREQUEST = 0 and AVL_READDATA = RAM_Q.
  - The t+1 cycle does not use the port, so the engine may be granted then.
- Control-register read: AVL_WAITREQUEST = 1 at t; data at t+1 with waitrequest 0.
- Control-register write: completes at t with waitrequest 0.
- The master must hold its request stable while waitrequest = 1.
- Uncontested cycle counts from the CMD write cycle:
  - FILL: BUSY falls 1202 cycles later (1 start + 1200 writes + FIN).
  - SCROLL: BUSY falls 2362 cycles later (1 start + 1160×2 + 40 + FIN).
- AVL_READDATA outside read data cycles: hold the last value.

## Test plan
- Reset, then read STATUS: 0x0; IRQ = 0; RAM_WREN/RAM_RDEN = 0.
- CPU writes 0xDEADBEEF to word 5 with BYTE_EN 0011, then reads word 5: exactly 1 write strobe with RAM_BYTEEN = 0011; the read returns RAM_Q with waitrequest high for exactly 1 cycle.
- FILL_DATA = 0x00200020, CMD = 0b101 with the CPU idle: 1200 writes covering addresses 0..1199; STATUS = 0b010 and IRQ = 1 at cycle 1202; writing STATUS = 0b010 clears IRQ.
- Preload word i = i, then SCROLL with FILL_DATA = 0: words 0..1159 hold i+40; words 1160..1199 hold 0; no address is ever ≥ 1200.
- SCROLL while the CPU issues back-to-back VRAM reads: grants alternate CPU/engine; the CPU sees waitrequest ≤ 2 cycles per read; the SCROLL result is identical to the uncontested case.
- CMD FILL issued while a SCROLL is running: ERR = 1; the SCROLL completes unaffected. Assert RESET mid-FILL: BUSY = 0 immediately; no further RAM_WREN.
